// File: rtl/combinational_pipe.sv
// Pipelined bitwise AND/OR/XOR/XNOR with valid/ready handshakes and full backpressure.
// Optional PIPE_PARITY_EN adds a parity bit (XOR-reduction of the result) travelling with each result.

module combinational_pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_v_i,
  input  logic          ld_d_i,
  input  logic          v_i,
  input  logic [PW-1:0] d_i,
  output logic          v_o,
  output logic [PW-1:0] d_o
);
  logic          v_q;
  logic [PW-1:0] d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      if (ld_v_i) v_q <= v_i;
      if (ld_d_i) d_q <= d_i;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;
endmodule

module combinational_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic [WIDTH-1:0] out_data
);
`ifdef PIPE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int PW = WIDTH + PAR_W;

  logic [WIDTH-1:0]             f_d;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][PW-1:0]      dat_pipe;
  logic [STAGES:0]              rdy;

  always_comb begin
    f_d = '0;
    case (in_op)
      2'd0:    f_d = in_x & in_y;
      2'd1:    f_d = in_x | in_y;
      2'd2:    f_d = in_x ^ in_y;
      default: f_d = ~(in_x ^ in_y);
    endcase
  end

  assign vld_pipe[0] = in_valid;
`ifdef PIPE_PARITY_EN
  assign dat_pipe[0] = {^f_d, f_d};
`else
  assign dat_pipe[0] = f_d;
`endif

  // Stage s can load whenever the consumer takes data or any stage from s onward holds a bubble;
  // written as a reduction so the chain has no self-referencing vector.
  assign rdy[STAGES] = out_ready;

  genvar s;
  generate
    for (s = 0; s < STAGES; s++) begin : g_stage
      logic ld_d;
      assign rdy[s] = out_ready | ~(&vld_pipe[STAGES:s+1]);
      if (s == 0) begin : g_first
        assign ld_d = rdy[0] & in_valid;
      end else begin : g_rest
        assign ld_d = rdy[s];
      end
      combinational_pipe_stage #(.PW(PW)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .ld_v_i (rdy[s]),
        .ld_d_i (ld_d),
        .v_i    (vld_pipe[s]),
        .d_i    (dat_pipe[s]),
        .v_o    (vld_pipe[s+1]),
        .d_o    (dat_pipe[s+1])
      );
    end
  endgenerate

  assign in_ready  = rdy[0];
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = dat_pipe[STAGES][WIDTH-1:0];
`ifdef PIPE_PARITY_EN
  assign out_parity = dat_pipe[STAGES][WIDTH];
`endif
endmodule

// File: tb/tb_combinational_pipe.sv
// Bench for combinational_pipe: directed cases on an 8/2 instance plus random scoreboarding
// of 8/2, 32/4 and 1/1 instances against a bitwise reference model.

module tb_combinational_pipe;
  localparam int AW = 8,  AS = 2;
  localparam int BW = 32, BS = 4;
  localparam int CW = 1,  CS = 1;

  typedef struct {
    logic [31:0] d;
    int          cyc;
    bit          ex;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_exact = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          a_iv, a_ir, a_ov, a_ordy, a_opar;
  logic [AW-1:0] a_x, a_y, a_od;
  logic [1:0]    a_op;
  logic          b_iv, b_ir, b_ov, b_ordy, b_opar;
  logic [BW-1:0] b_x, b_y, b_od;
  logic [1:0]    b_op;
  logic          c_iv, c_ir, c_ov, c_ordy, c_opar;
  logic [CW-1:0] c_x, c_y, c_od;
  logic [1:0]    c_op;

  exp_t qa[$], qb[$], qc[$];

  combinational_pipe #(.WIDTH(AW), .STAGES(AS)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_x(a_x), .in_y(a_y), .in_op(a_op),
    .out_valid(a_ov), .out_ready(a_ordy),
`ifdef PIPE_PARITY_EN
    .out_parity(a_opar),
`endif
    .out_data(a_od));

  combinational_pipe #(.WIDTH(BW), .STAGES(BS)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_x(b_x), .in_y(b_y), .in_op(b_op),
    .out_valid(b_ov), .out_ready(b_ordy),
`ifdef PIPE_PARITY_EN
    .out_parity(b_opar),
`endif
    .out_data(b_od));

  combinational_pipe #(.WIDTH(CW), .STAGES(CS)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_x(c_x), .in_y(c_y), .in_op(c_op),
    .out_valid(c_ov), .out_ready(c_ordy),
`ifdef PIPE_PARITY_EN
    .out_parity(c_opar),
`endif
    .out_data(c_od));

`ifndef PIPE_PARITY_EN
  assign a_opar = 1'b0;
  assign b_opar = 1'b0;
  assign c_opar = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] op, input int w);
    logic [31:0] r;
    logic [31:0] m;
    case (op)
      2'd0:    r = x & y;
      2'd1:    r = x | y;
      2'd2:    r = x ^ y;
      default: r = ~(x ^ y);
    endcase
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return r & m;
  endfunction

  function automatic logic ref_par(input logic [31:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Scoreboards: push on accept, pop on delivery; reset flushes everything in flight.
  always @(negedge clk) begin
    exp_t e;
    if (rst) qa.delete();
    else begin
      if (a_ov && a_ordy) begin
        chk("a_q_nonempty", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_data", 32'(a_od), e.d);
`ifdef PIPE_PARITY_EN
          chk("a_par", 32'(a_opar), 32'(ref_par(e.d)));
`endif
          if (e.ex) chk("a_lat", 32'(cyc - e.cyc), 32'(AS));
          else      chk("a_lat_min", 32'((cyc - e.cyc) >= AS), 32'd1);
        end
      end
      if (a_iv && a_ir) qa.push_back('{d: ref_f(32'(a_x), 32'(a_y), a_op, AW), cyc: cyc, ex: lat_exact});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) qb.delete();
    else begin
      if (b_ov && b_ordy) begin
        chk("b_q_nonempty", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_data", b_od, e.d);
`ifdef PIPE_PARITY_EN
          chk("b_par", 32'(b_opar), 32'(ref_par(e.d)));
`endif
          if (e.ex) chk("b_lat", 32'(cyc - e.cyc), 32'(BS));
          else      chk("b_lat_min", 32'((cyc - e.cyc) >= BS), 32'd1);
        end
      end
      if (b_iv && b_ir) qb.push_back('{d: ref_f(b_x, b_y, b_op, BW), cyc: cyc, ex: lat_exact});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) qc.delete();
    else begin
      if (c_ov && c_ordy) begin
        chk("c_q_nonempty", 32'(qc.size() != 0), 32'd1);
        if (qc.size() != 0) begin
          e = qc.pop_front();
          chk("c_data", 32'(c_od), e.d);
`ifdef PIPE_PARITY_EN
          chk("c_par", 32'(c_opar), 32'(ref_par(e.d)));
`endif
          if (e.ex) chk("c_lat", 32'(cyc - e.cyc), 32'(CS));
          else      chk("c_lat_min", 32'((cyc - e.cyc) >= CS), 32'd1);
        end
      end
      if (c_iv && c_ir) qc.push_back('{d: ref_f(32'(c_x), 32'(c_y), c_op, CW), cyc: cyc, ex: lat_exact});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cycle(input bit hold);
    logic [31:0] r;
    r = $urandom; a_iv = (r[1:0] != 2'd0); a_op = r[3:2]; a_ordy = hold | (r[5:4] != 2'd0);
    b_iv = (r[7:6] != 2'd0); b_op = r[9:8]; b_ordy = hold | (r[11:10] != 2'd0);
    c_iv = (r[13:12] != 2'd0); c_op = r[15:14]; c_ordy = hold | (r[17:16] != 2'd0);
    c_x = r[18]; c_y = r[19];
    r = $urandom; a_x = r[7:0]; a_y = r[15:8];
    b_x = $urandom; b_y = $urandom;
  endtask

  task automatic idle_all();
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
    a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
  endtask

  logic [7:0] sexp [4];

  initial begin
    sexp = '{8'h30, 8'hFC, 8'hCC, 8'h33};
    a_x = '0; a_y = '0; a_op = '0; b_x = '0; b_y = '0; b_op = '0; c_x = '0; c_y = '0; c_op = '0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ov", 32'(a_ov), 32'd0);
    chk("rst_a_od", 32'(a_od), 32'd0);
    chk("rst_a_par", 32'(a_opar), 32'd0);
    chk("rst_b_ov", 32'(b_ov), 32'd0);
    chk("rst_b_od", b_od, 32'd0);
    chk("rst_c_ov", 32'(c_ov), 32'd0);
    chk("rst_c_od", 32'(c_od), 32'd0);
    rst = 1'b0;
    step();

    // Streaming, all four ops back to back
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin a_iv = 1'b1; a_x = 8'hF0; a_y = 8'h3C; a_op = 2'(k); end
      else a_iv = 1'b0;
      @(negedge clk);
      if (k >= 2 && k < 6) begin
        chk("stream_v", 32'(a_ov), 32'd1);
        chk("stream_d", 32'(a_od), 32'(sexp[k-2]));
      end else chk("stream_idle", 32'(a_ov), 32'd0);
      step();
    end

    // Backpressure: third input refused, head stable
    a_ordy = 1'b0;
    a_iv = 1'b1; a_x = 8'h5A; a_y = 8'h0F; a_op = 2'd0;
    @(negedge clk); chk("bp_ir0", 32'(a_ir), 32'd1); step();
    a_x = 8'h12; a_y = 8'h34; a_op = 2'd1;
    @(negedge clk); chk("bp_ir1", 32'(a_ir), 32'd1); step();
    a_x = 8'hAA; a_y = 8'h55; a_op = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ir_full", 32'(a_ir), 32'd0);
      chk("bp_v", 32'(a_ov), 32'd1);
      chk("bp_hold", 32'(a_od), 32'h0A);
      step();
    end
    // Simultaneous deliver + accept while full
    a_ordy = 1'b1;
    @(negedge clk);
    chk("sim_ir", 32'(a_ir), 32'd1);
    chk("sim_d0", 32'(a_od), 32'h0A);
    step();
    a_iv = 1'b0;
    @(negedge clk); chk("sim_v1", 32'(a_ov), 32'd1); chk("sim_d1", 32'(a_od), 32'h36); step();
    @(negedge clk); chk("sim_v2", 32'(a_ov), 32'd1); chk("sim_d2", 32'(a_od), 32'hFF); step();
    @(negedge clk); chk("sim_empty", 32'(a_ov), 32'd0); step();

    // Asynchronous reset with two results in flight
    a_ordy = 1'b0;
    a_iv = 1'b1; a_x = 8'h0F; a_y = 8'hFF; a_op = 2'd0; step();
    a_x = 8'h81; a_y = 8'h18; a_op = 2'd1; step();
    a_iv = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_v", 32'(a_ov), 32'd0);
    chk("arst_d", 32'(a_od), 32'd0);
    chk("arst_par", 32'(a_opar), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; a_iv = 1'b0; a_ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("flush_v", 32'(a_ov), 32'd0);
      chk("flush_ir", 32'(a_ir), 32'd1);
      step();
    end

`ifdef PIPE_PARITY_EN
    a_ordy = 1'b0;
    a_iv = 1'b1; a_x = 8'h07; a_y = 8'h00; a_op = 2'd2; step();
    a_x = 8'hFF; a_y = 8'h03; a_op = 2'd0; step();
    a_iv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("par_d0", 32'(a_od), 32'h07);
      chk("par_p0", 32'(a_opar), 32'd1);
      step();
    end
    a_ordy = 1'b1;
    @(negedge clk); chk("par_d0_out", 32'(a_od), 32'h07); step();
    @(negedge clk); chk("par_d1", 32'(a_od), 32'h03); chk("par_p1", 32'(a_opar), 32'd0); step();
    step();
`endif

    // 32-bit XNOR corner on the 4-stage instance
    b_iv = 1'b1; b_x = 32'hFFFF_FFFF; b_y = 32'h0; b_op = 2'd3; step();
    b_iv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("xnor32_v", 32'(b_ov), 32'd1);
    chk("xnor32_d", b_od, 32'h0);
    step();
    repeat (6) step();

    // Random, consumer always ready: exact latency
    lat_exact = 1'b1;
    repeat (300) begin rnd_cycle(1'b1); step(); end
    idle_all();
    repeat (8) step();
    lat_exact = 1'b0;
    // Random with backpressure
    repeat (600) begin rnd_cycle(1'b0); step(); end
    idle_all();
    repeat (12) step();
    @(negedge clk);
    chk("a_drained", 32'(qa.size()), 32'd0);
    chk("b_drained", 32'(qb.size()), 32'd0);
    chk("c_drained", 32'(qc.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
